axi4_sram_slave: RTL and testbench

AXI4 slave responder backed by an internal word-addressed memory. It terminates the M1 master's write and read bursts at the S1 slave port, and drives AWREADY/WREADY/BVALID/BID/BRESP and ARREADY/RVALID/RDATA/RID/RRESP/RLAST to full protocol compliance. Write and read channels are independent, with one outstanding transaction per direction. It is the DUT end that the axi4pc checker binds against.

---
 rtl/axi4_sram_slave_pkg.sv | 34 +++
 rtl/axi4_sram_slave_addr_gen.sv | 38 +++
 rtl/axi4_sram_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_sram_slave_pkg.sv
// Shared AXI4 encodings and FSM state types for the SRAM-backed slave.
// Response ordering is numeric, so the most severe response is simply the larger code.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    function automatic resp_e worst_resp(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_sram_slave_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus burst-configuration error.
// Illegal wrap lengths and the reserved burst type step as INCR.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [LEN_W-1:0]  len_i,
    input  burst_e            burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              cfg_err_o
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] win_mask;
    logic [ADDR_W-1:0] step_addr;
    logic              wrap_ok;

    always_comb begin
        incr      = ADDR_W'(1) << size_i;
        win_mask  = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        step_addr = addr_i + incr;
        wrap_ok   = (len_i == LEN_W'(1)) || (len_i == LEN_W'(3)) ||
                    (len_i == LEN_W'(7)) || (len_i == LEN_W'(15));
        cfg_err_o = (size_i > 3'd2) || (burst_i == RSVD) || ((burst_i == WRAP) && !wrap_ok);

        next_addr_o = step_addr;
        case (burst_i)
            FIXED:   next_addr_o = addr_i;
            WRAP:    if (wrap_ok) next_addr_o = (addr_i & ~win_mask) | (step_addr & win_mask);
            default: next_addr_o = step_addr;
        endcase
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave terminating one write and one read burst at a time into an internal word memory.
// Write and read FSMs are independent; a same-cycle read of a word being written sees the old data.
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 32,
    parameter int                ID_W   = 8,
    parameter int                LEN_W  = 4,
    parameter int                DEPTH  = 1024,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    localparam int               STRB_W = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY
);

    localparam int              IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(DEPTH * 4);

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    // ---------------- write channel ----------------
    wr_state_e         w_state_q;
    logic [ID_W-1:0]   w_id_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [LEN_W-1:0]  w_len_q;
    logic [2:0]        w_size_q;
    burst_e            w_burst_q;
    logic [LEN_W:0]    w_cnt_q;
    resp_e             w_err_q;
    logic [ID_W-1:0]   bid_q;
    resp_e             bresp_q;
    logic              bvalid_q;

    logic [ADDR_W-1:0] w_next;
    logic              w_cfg_err;
    logic              w_hs;
    logic              w_dec;
    logic              w_last_beat;
    resp_e             w_beat_resp;

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
        .addr_i      (w_addr_q),
        .size_i      (w_size_q),
        .len_i       (w_len_q),
        .burst_i     (w_burst_q),
        .next_addr_o (w_next),
        .cfg_err_o   (w_cfg_err)
    );

    always_comb begin
        w_hs        = (w_state_q == W_DATA) && WVALID;
        w_dec       = !in_win(w_addr_q);
        w_last_beat = (w_cnt_q == (LEN_W+1)'(1));
        w_beat_resp = OKAY;
        if (w_dec)                              w_beat_resp = DECERR;
        else if (w_cfg_err || (WLAST != w_last_beat)) w_beat_resp = SLVERR;
    end

    // Memory has no reset; out-of-window beats never touch it.
    always_ff @(posedge ACLK) begin
        if (w_hs && !w_dec) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= FIXED;
            w_cnt_q   <= '0;
            w_err_q   <= OKAY;
            bid_q     <= '0;
            bresp_q   <= OKAY;
            bvalid_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (AWVALID) begin
                    w_id_q    <= AWID;
                    w_addr_q  <= AWADDR;
                    w_len_q   <= AWLEN;
                    w_size_q  <= AWSIZE;
                    w_burst_q <= burst_e'(AWBURST);
                    w_cnt_q   <= {1'b0, AWLEN} + (LEN_W+1)'(1);
                    w_err_q   <= OKAY;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (WVALID) begin
                    w_addr_q <= w_next;
                    w_cnt_q  <= w_cnt_q - (LEN_W+1)'(1);
                    w_err_q  <= worst_resp(w_err_q, w_beat_resp);
                    // Burst length comes from the count; WLAST only feeds the error.
                    if (w_last_beat) begin
                        bvalid_q  <= 1'b1;
                        bid_q     <= w_id_q;
                        bresp_q   <= worst_resp(w_err_q, w_beat_resp);
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    bvalid_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign AWREADY = (w_state_q == W_IDLE);
    assign WREADY  = (w_state_q == W_DATA);
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;

    // ---------------- read channel ----------------
    rd_state_e         r_state_q;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [LEN_W-1:0]  r_len_q;
    logic [2:0]        r_size_q;
    burst_e            r_burst_q;
    logic [LEN_W-1:0]  r_cnt_q;
    logic [DATA_W-1:0] rdata_q;
    resp_e             rresp_q;
    logic              rlast_q;
    logic              rvalid_q;

    logic              r_idle;
    logic [ADDR_W-1:0] r_gen_addr;
    logic [2:0]        r_gen_size;
    logic [LEN_W-1:0]  r_gen_len;
    burst_e            r_gen_burst;
    logic [ADDR_W-1:0] r_next;
    logic              r_cfg_err;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    resp_e             ld_resp;

    // In idle the generator sees the incoming request so beat 0's response is ready at accept.
    always_comb begin
        r_idle      = (r_state_q == R_IDLE);
        r_gen_addr  = r_idle ? ARADDR : r_addr_q;
        r_gen_size  = r_idle ? ARSIZE : r_size_q;
        r_gen_len   = r_idle ? ARLEN  : r_len_q;
        r_gen_burst = r_idle ? burst_e'(ARBURST) : r_burst_q;
    end

    axi4_burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
        .addr_i      (r_gen_addr),
        .size_i      (r_gen_size),
        .len_i       (r_gen_len),
        .burst_i     (r_gen_burst),
        .next_addr_o (r_next),
        .cfg_err_o   (r_cfg_err)
    );

    always_comb begin
        ld_addr = r_idle ? ARADDR : r_next;
        ld_data = '0;
        ld_resp = OKAY;
        if (!in_win(ld_addr)) begin
            ld_resp = DECERR;
        end else begin
            ld_data = mem[word_idx(ld_addr)];
            if (r_cfg_err) ld_resp = SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= FIXED;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ARVALID) begin
                    rid_q     <= ARID;
                    r_addr_q  <= ARADDR;
                    r_len_q   <= ARLEN;
                    r_size_q  <= ARSIZE;
                    r_burst_q <= burst_e'(ARBURST);
                    r_cnt_q   <= ARLEN;
                    rdata_q   <= ld_data;
                    rresp_q   <= ld_resp;
                    rlast_q   <= (ARLEN == '0);
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (RREADY) begin
                    if (rlast_q) begin
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        r_state_q <= R_IDLE;
                    end else begin
                        r_addr_q <= r_next;
                        rdata_q  <= ld_data;
                        rresp_q  <= ld_resp;
                        rlast_q  <= (r_cnt_q == LEN_W'(1));
                        r_cnt_q  <= r_cnt_q - LEN_W'(1);
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign ARREADY = r_idle;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: drivers push expected B/R responses into queues,
// a monitor pops and compares each completed handshake.
module tb_axi4_sram_slave;

    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_SLV = 2'b10;
    localparam logic [1:0] R_DEC = 2'b11;
    localparam logic [1:0] B_INCR = 2'b01;
    localparam logic [1:0] B_WRAP = 2'b10;
    localparam int         TMO = 100;

    logic        ACLK;
    logic        ARESETn;
    logic [7:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi4_sram_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [9:0]  exp_b_q[$];   // {id, resp}
    logic [42:0] exp_r_q[$];   // {id, data, resp, last}
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic push_r(input logic [7:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
        exp_r_q.push_back({id, data, resp, last});
    endtask

    // ---------------- monitor ----------------
    always @(negedge ACLK) begin
        #2;
        if (ARESETn && BVALID && BREADY) begin
            if (exp_b_q.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected actual=%h required=none", {BID, BRESP});
            end else begin
                check("b_resp", 64'({BID, BRESP}), 64'(exp_b_q.pop_front()));
            end
        end
        if (ARESETn && RVALID && RREADY) begin
            if (exp_r_q.size() == 0) begin
                total++; bad++;
                $display("FAIL r_unexpected actual=%h required=none", {RID, RDATA, RRESP, RLAST});
            end else begin
                check("r_beat", 64'({RID, RDATA, RRESP, RLAST}), 64'(exp_r_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input logic [1:0] burst, input int early, input logic [1:0] exp_resp);
        int t;
        exp_b_q.push_back({id, exp_resp});
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < TMO) begin @(negedge ACLK); t++; end
        if (t >= TMO) timeout_fail("aw_wait");
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wd[i]; WSTRB = ws[i];
            WLAST = (i == int'(len)) || (i == early);
            WVALID = 1'b1;
            t = 0;
            while (!WREADY && t < TMO) begin @(negedge ACLK); t++; end
            if (t >= TMO) timeout_fail("w_wait");
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] id, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] exp_resp);
        wd[0] = data; ws[0] = 4'hF;
        write_burst(id, addr, 4'd0, B_INCR, -1, exp_resp);
    endtask

    task automatic read_req(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst);
        int t;
        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < TMO) begin @(negedge ACLK); t++; end
        if (t >= TMO) timeout_fail("ar_wait");
        @(negedge ACLK);
        ARVALID = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0) && t < 4 * TMO) begin
            @(negedge ACLK); t++;
        end
        if (t >= 4 * TMO) begin
            timeout_fail("drain");
            exp_b_q.delete();
            exp_r_q.delete();
        end
        @(negedge ACLK);
    endtask

    // ---------------- stimulus ----------------
    logic [43:0] snap;

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_awready", 64'(AWREADY), 64'(1));
        check("rst_arready", 64'(ARREADY), 64'(1));
        check("rst_wready",  64'(WREADY),  64'(0));
        check("rst_b_outs",  64'({BVALID, BID, BRESP}), 64'(0));
        check("rst_r_outs",  64'({RVALID, RLAST, RID, RRESP, RDATA}), 64'(0));
        ARESETn = 1'b1;

        // single write then read, one-cycle read latency
        write_word(8'h5A, 32'h10, 32'hDEAD_BEEF, R_OK);
        drain();
        push_r(8'h3C, 32'hDEAD_BEEF, R_OK, 1'b1);
        read_req(8'h3C, 32'h10, 4'd0, B_INCR);
        check("r_latency", 64'(RVALID), 64'(1));
        drain();

        // INCR len=3 with a half-word strobe on beat 2
        write_word(8'h01, 32'h108, 32'hCAFE_F00D, R_OK);
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        ws[0] = 4'hF;   ws[1] = 4'hF;   ws[2] = 4'h3;   ws[3] = 4'hF;
        write_burst(8'h02, 32'h100, 4'd3, B_INCR, -1, R_OK);
        drain();
        push_r(8'h03, 32'h11, R_OK, 1'b0);
        push_r(8'h03, 32'h22, R_OK, 1'b0);
        push_r(8'h03, 32'hCAFE_0033, R_OK, 1'b0);
        push_r(8'h03, 32'h44, R_OK, 1'b1);
        read_req(8'h03, 32'h100, 4'd3, B_INCR);
        drain();

        // WRAP len=3 from 0x108, then illegal WRAP len=2
        push_r(8'h04, 32'hCAFE_0033, R_OK, 1'b0);
        push_r(8'h04, 32'h44, R_OK, 1'b0);
        push_r(8'h04, 32'h11, R_OK, 1'b0);
        push_r(8'h04, 32'h22, R_OK, 1'b1);
        read_req(8'h04, 32'h108, 4'd3, B_WRAP);
        drain();
        push_r(8'h05, 32'h11, R_SLV, 1'b0);
        push_r(8'h05, 32'h22, R_SLV, 1'b0);
        push_r(8'h05, 32'hCAFE_0033, R_SLV, 1'b1);
        read_req(8'h05, 32'h100, 4'd2, B_WRAP);
        drain();

        // R backpressure: one beat through, then RREADY low for 5 cycles
        RREADY = 1'b0;
        push_r(8'h06, 32'h11, R_OK, 1'b0);
        push_r(8'h06, 32'h22, R_OK, 1'b0);
        push_r(8'h06, 32'hCAFE_0033, R_OK, 1'b0);
        push_r(8'h06, 32'h44, R_OK, 1'b1);
        read_req(8'h06, 32'h100, 4'd3, B_INCR);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        snap = {RVALID, RID, RDATA, RLAST, RRESP};
        check("r_stall_start", 64'(snap), 64'({1'b1, 8'h06, 32'h22, 1'b0, R_OK}));
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check("r_stall_hold", 64'({RVALID, RID, RDATA, RLAST, RRESP}), 64'(snap));
        end
        RREADY = 1'b1;
        drain();

        // B backpressure: BREADY low for 3 cycles
        BREADY = 1'b0;
        write_word(8'h77, 32'h200, 32'h1234_5678, R_OK);
        begin
            int t;
            t = 0;
            while (!BVALID && t < TMO) begin @(negedge ACLK); t++; end
            if (t >= TMO) timeout_fail("bvalid_wait");
        end
        snap = 44'({BVALID, BID, BRESP});
        check("b_stall_start", 64'(snap), 64'({1'b1, 8'h77, R_OK}));
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            check("b_stall_hold", 64'({BVALID, BID, BRESP}), 64'(snap));
        end
        BREADY = 1'b1;
        drain();

        // out-of-window write/read, memory below stays intact
        write_word(8'h10, 32'h0, 32'hA5A5_A5A5, R_OK);
        write_word(8'h11, 32'h1000, 32'h0BAD_F00D, R_DEC);
        drain();
        push_r(8'h12, 32'hA5A5_A5A5, R_OK, 1'b1);
        read_req(8'h12, 32'h0, 4'd0, B_INCR);
        drain();
        push_r(8'h13, 32'h0, R_DEC, 1'b1);
        read_req(8'h13, 32'h1000, 4'd0, B_INCR);
        drain();

        // early WLAST on beat 2 of len=3: still four beats, SLVERR
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; wd[3] = 32'h4;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;  ws[3] = 4'hF;
        write_burst(8'h21, 32'h300, 4'd3, B_INCR, 1, R_SLV);
        drain();
        push_r(8'h22, 32'h1, R_OK, 1'b0);
        push_r(8'h22, 32'h2, R_OK, 1'b0);
        push_r(8'h22, 32'h3, R_OK, 1'b0);
        push_r(8'h22, 32'h4, R_OK, 1'b1);
        read_req(8'h22, 32'h300, 4'd3, B_INCR);
        drain();

        // reset during beat 2 of a len=7 read
        RREADY = 1'b0;
        push_r(8'h99, 32'h11, R_OK, 1'b0);
        read_req(8'h99, 32'h100, 4'd7, B_INCR);
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        check("rst_mid_beat2", 64'({RVALID, RDATA}), 64'({1'b1, 32'h22}));
        #3;
        ARESETn = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'({RVALID, RLAST}), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        RREADY = 1'b1;
        @(negedge ACLK);
        check("rst_rel_arready", 64'(ARREADY), 64'(1));
        check("rst_rel_queue", 64'(exp_r_q.size()), 64'(0));
        push_r(8'h42, 32'hDEAD_BEEF, R_OK, 1'b1);
        read_req(8'h42, 32'h10, 4'd0, B_INCR);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
